// File: rtl/ram_verifier.sv
// Post-erase RAM read-back checker: walks START_RAM..END_RAM and compares every byte to PATTERN.
// Latency 2 + controller latency ena-cycles per address; waits on rd_valid, bails out after TIMEOUT ena-cycles.
module ram_verifier #(
  parameter logic [24:0] START_RAM = 25'h0000000,
  parameter logic [24:0] END_RAM   = 25'h000FFFF,
  parameter logic [7:0]  PATTERN   = 8'hFF,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ena,
  input  logic        trigger,
  output logic        checking,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [24:0] first_err_addr,
  output logic [7:0]  first_err_data,
  output logic        rd,
  output logic [24:0] addr,
  input  logic [7:0]  rdata,
  input  logic        rd_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic EMPTY_RANGE = (END_RAM < START_RAM);

  state_t      state_q, state_d;
  logic        trig_dly_q, trig_dly_d;
  logic [24:0] pos_q, pos_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        checking_q, checking_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [15:0] err_count_q, err_count_d;
  logic [24:0] first_err_addr_q, first_err_addr_d;
  logic [7:0]  first_err_data_q, first_err_data_d;
  logic        rd_q, rd_d;
  logic [24:0] addr_q, addr_d;

  logic start;
  logic last_addr;
  logic mismatch;
  logic wait_expired;

  assign start        = trigger & ~trig_dly_q & (state_q == ST_IDLE);
  assign last_addr    = (pos_q == END_RAM);
  assign mismatch     = rd_valid & (rdata != PATTERN);
  assign wait_expired = ~rd_valid & (wcnt_q == TIMEOUT - 8'd1);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = EMPTY_RANGE ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT: begin
          if (rd_valid) begin
            state_d = last_addr ? ST_DONE : ST_ISSUE;
          end else if (wait_expired) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and output next values; everything holds when ena is low
  always_comb begin
    trig_dly_d       = trig_dly_q;
    pos_d            = pos_q;
    wcnt_d           = wcnt_q;
    checking_d       = checking_q;
    done_d           = done_q;
    pass_d           = pass_q;
    timeout_d        = timeout_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    first_err_data_d = first_err_data_q;
    rd_d             = rd_q;
    addr_d           = addr_q;

    if (ena) begin
      trig_dly_d = trigger;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            done_d           = 1'b0;
            pass_d           = 1'b0;
            timeout_d        = 1'b0;
            err_count_d      = 16'h0000;
            first_err_addr_d = 25'h0000000;
            first_err_data_d = 8'h00;
            pos_d            = START_RAM;
            checking_d       = 1'b1;
          end
        end
        ST_ISSUE: begin
          rd_d   = 1'b1;
          addr_d = pos_q;
          wcnt_d = 8'h00;
        end
        ST_WAIT: begin
          rd_d = 1'b0;
          if (rd_valid) begin
            if (mismatch) begin
              err_count_d = (err_count_q == 16'hFFFF) ? 16'hFFFF : err_count_q + 16'd1;
              if (err_count_q == 16'h0000) begin
                first_err_addr_d = pos_q;
                first_err_data_d = rdata;
              end
            end
            if (!last_addr) begin
              pos_d = pos_q + 25'd1;
            end
          end else begin
            wcnt_d = wcnt_q + 8'd1;
            if (wait_expired) begin
              timeout_d = 1'b1;
            end
          end
        end
        ST_DONE: begin
          checking_d = 1'b0;
          done_d     = 1'b1;
          // err_count already includes the final compare by the time DONE is reached
          pass_d     = (err_count_q == 16'h0000) & ~timeout_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_dly_q       <= 1'b0;
      pos_q            <= 25'h0000000;
      wcnt_q           <= 8'h00;
      checking_q       <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      timeout_q        <= 1'b0;
      err_count_q      <= 16'h0000;
      first_err_addr_q <= 25'h0000000;
      first_err_data_q <= 8'h00;
      rd_q             <= 1'b0;
      addr_q           <= 25'h0000000;
    end else begin
      trig_dly_q       <= trig_dly_d;
      pos_q            <= pos_d;
      wcnt_q           <= wcnt_d;
      checking_q       <= checking_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      timeout_q        <= timeout_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_data_q <= first_err_data_d;
      rd_q             <= rd_d;
      addr_q           <= addr_d;
    end
  end

  assign checking       = checking_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_data = first_err_data_q;
  assign rd             = rd_q;
  assign addr           = addr_q;

  a_rd_in_check: assert property (@(posedge clk) disable iff (!reset_n) rd_q |-> checking_q);
  a_done_idle:   assert property (@(posedge clk) disable iff (!reset_n) done_q |-> !checking_q);
  a_pos_bound:   assert property (@(posedge clk) disable iff (!reset_n)
                                  (checking_q && !EMPTY_RANGE) |-> (pos_q <= END_RAM));

endmodule
